// File: rtl/kim_stream_sink_checker.sv
// Stream sink: programmable backpressure on s_ready, incrementing-sequence
// data checker with saturating beat/error counters and first-error capture.
module kim_stream_sink_checker #(
  parameter int          DATA_WIDTH = 32,
  parameter int          CNT_WIDTH  = 32,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            throttle_mode,
  input  logic [DATA_WIDTH-1:0] expect_start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_flag,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic [DATA_WIDTH-1:0] first_err_expect
);

  localparam logic [0:0]  ST_IDLE = 1'b0;
  localparam logic [0:0]  ST_RUN  = 1'b1;
  localparam logic [15:0] SEED    =
    (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [0:0]            state;
  logic [15:0]           lfsr;
  logic [15:0]           lfsr_nxt;
  logic [1:0]            phase;
  logic [DATA_WIDTH-1:0] expected;
  logic                  ready_nxt;
  logic                  ready_start;
  logic                  xfer;
  logic                  mism;

  assign busy = (state == ST_RUN);
  assign xfer = busy && s_valid && s_ready;
  assign mism = (s_data != expected);

  // s_ready in a cycle reflects the throttle state held in that cycle
  always_comb begin
    lfsr_nxt    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    ready_nxt   = 1'b0;
    ready_start = 1'b0;
    unique case (throttle_mode)
      2'd0: begin
        ready_nxt   = 1'b1;
        ready_start = 1'b1;
      end
      2'd1: begin
        ready_nxt   = lfsr_nxt[0];
        ready_start = SEED[0];
      end
      2'd2: begin
        ready_nxt   = (phase == 2'd2);
        ready_start = 1'b0;
      end
      default: begin
        ready_nxt   = 1'b0;
        ready_start = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      s_ready          <= 1'b0;
      lfsr             <= SEED;
      phase            <= 2'd0;
      expected         <= '0;
      beat_count       <= '0;
      err_count        <= '0;
      err_flag         <= 1'b0;
      first_err_data   <= '0;
      first_err_expect <= '0;
    end else if (start) begin
      state            <= ST_RUN;
      s_ready          <= ready_start;
      lfsr             <= SEED;
      phase            <= 2'd0;
      expected         <= expect_start;
      beat_count       <= '0;
      err_count        <= '0;
      err_flag         <= 1'b0;
      first_err_data   <= '0;
      first_err_expect <= '0;
    end else if (state == ST_RUN) begin
      lfsr  <= lfsr_nxt;
      phase <= phase + 2'd1;
      if (stop) begin
        state   <= ST_IDLE;
        s_ready <= 1'b0;
      end else begin
        s_ready <= ready_nxt;
      end
      if (xfer) begin
        expected <= s_data + DATA_WIDTH'(1);
        if (beat_count != '1)
          beat_count <= beat_count + CNT_WIDTH'(1);
        if (mism) begin
          if (err_count != '1)
            err_count <= err_count + CNT_WIDTH'(1);
          if (!err_flag) begin
            err_flag         <= 1'b1;
            first_err_data   <= s_data;
            first_err_expect <= expected;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_kim_stream_sink_checker.sv
// Directed bench for kim_stream_sink_checker.
// Inputs driven 1ns after the rising edge, outputs sampled there too.
module tb_kim_stream_sink_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [1:0]  throttle_mode;
  logic [31:0] expect_start;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        busy;
  logic [31:0] beat_count;
  logic [31:0] err_count;
  logic        err_flag;
  logic [31:0] first_err_data;
  logic [31:0] first_err_expect;

  int n_cmp = 0;
  int n_bad = 0;

  kim_stream_sink_checker dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .stop             (stop),
    .throttle_mode    (throttle_mode),
    .expect_start     (expect_start),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_data           (s_data),
    .busy             (busy),
    .beat_count       (beat_count),
    .err_count        (err_count),
    .err_flag         (err_flag),
    .first_err_data   (first_err_data),
    .first_err_expect (first_err_expect)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [31:0] e);
    throttle_mode = m;
    expect_start  = e;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    s_valid = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("send_timeout", 64'd1, 64'd0);
    step();
    s_valid = 1'b0;
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  initial begin
    logic [15:0] ref_lfsr;
    logic [31:0] d;
    int          bad;
    int          cyc;

    rst = 1'b1; start = 1'b0; stop = 1'b0; throttle_mode = 2'd0;
    expect_start = '0; s_valid = 1'b0; s_data = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_busy",   busy, 0);
    chk("rst_ready",  s_ready, 0);
    chk("rst_beats",  beat_count, 0);
    chk("rst_errs",   err_count, 0);
    chk("rst_flag",   err_flag, 0);
    chk("rst_fed",    first_err_data, 0);
    chk("rst_fee",    first_err_expect, 0);

    // mode 0 back-to-back
    do_start(2'd0, 32'h10);
    chk("m0_busy", busy, 1);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (s_ready !== 1'b1) bad++;
      s_valid = 1'b1;
      s_data  = 32'h10 + i;
      step();
    end
    chk("m0_ready_always", bad, 0);
    do_stop();
    chk("m0_beats", beat_count, 16);
    chk("m0_errs",  err_count, 0);
    chk("m0_flag",  err_flag, 0);
    chk("m0_stop_busy",  busy, 0);
    chk("m0_stop_ready", s_ready, 0);

    // drop and swap
    do_start(2'd0, 32'h0);
    send(32'h0); send(32'h1); send(32'h3); send(32'h4);
    chk("drop_errs", err_count, 1);
    chk("drop_flag", err_flag, 1);
    chk("drop_fed",  first_err_data, 32'h3);
    chk("drop_fee",  first_err_expect, 32'h2);
    send(32'h5); send(32'h7); send(32'h6);
    chk("swap_errs",  err_count, 3);
    chk("swap_beats", beat_count, 7);
    chk("swap_fed",   first_err_data, 32'h3);
    chk("swap_fee",   first_err_expect, 32'h2);
    do_stop();

    // mode 1 lfsr throttle, 1000 beats
    do_start(2'd1, 32'h0);
    ref_lfsr = 16'hACE1;
    d = 0; bad = 0; cyc = 0;
    s_valid = 1'b1;
    while (d < 1000 && cyc < 20000) begin
      if (s_ready !== ref_lfsr[0]) bad++;
      s_data = d;
      if (s_ready) d++;
      step();
      ref_lfsr = lfsr_adv(ref_lfsr);
      cyc++;
    end
    chk("m1_budget", (cyc < 20000), 1);
    chk("m1_lfsr_ready", bad, 0);
    do_stop();
    chk("m1_beats", beat_count, 1000);
    chk("m1_errs",  err_count, 0);

    // mode 2: one in four
    do_start(2'd2, 32'h100);
    s_valid = 1'b1;
    d = 32'h100; bad = 0;
    for (int k = 1; k <= 32; k++) begin
      if (s_ready !== ((k % 4) == 0)) bad++;
      s_data = d;
      if (s_ready) d++;
      step();
    end
    chk("m2_ready_pattern", bad, 0);
    chk("m2_beats", beat_count, 8);
    chk("m2_errs",  err_count, 0);
    do_stop();

    // wrap
    do_start(2'd0, 32'hFFFF_FFFE);
    send(32'hFFFF_FFFE); send(32'hFFFF_FFFF);
    send(32'h0); send(32'h1);
    chk("wrap_beats", beat_count, 4);
    chk("wrap_errs",  err_count, 0);
    send(32'h9);
    chk("wrap_err1", err_count, 1);

    // restart mid-stream
    s_valid = 1'b1;
    s_data  = 32'h55;
    do_start(2'd0, 32'h0);
    s_valid = 1'b0;
    chk("restart_beats", beat_count, 0);
    chk("restart_errs",  err_count, 0);
    chk("restart_flag",  err_flag, 0);
    chk("restart_busy",  busy, 1);

    // reset mid-run with a transfer presented
    send(32'h0); send(32'h5);
    s_valid = 1'b1;
    s_data  = 32'h6;
    rst = 1'b1;
    step();
    rst = 1'b0;
    s_valid = 1'b0;
    chk("mrst_busy",  busy, 0);
    chk("mrst_ready", s_ready, 0);
    chk("mrst_beats", beat_count, 0);
    chk("mrst_errs",  err_count, 0);
    chk("mrst_flag",  err_flag, 0);
    chk("mrst_fed",   first_err_data, 0);

    // mode 3 never ready
    do_start(2'd3, 32'h0);
    s_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      s_data = k;
      if (s_ready !== 1'b0 || beat_count !== 0) bad++;
      step();
    end
    chk("m3_blocked", bad, 0);
    chk("m3_beats", beat_count, 0);
    s_valid = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("m3_stopped", busy, 0);

    // start wins over stop
    start = 1'b1;
    stop  = 1'b1;
    throttle_mode = 2'd0;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("start_wins_busy",  busy, 1);
    chk("start_wins_ready", s_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kim_stream_sink_checker.md
# kim_stream_sink_checker

Receiving-end endpoint for the valid/ready streams carried by the skid-buffered FIFO. It acts as the downstream consumer: it drives `s_ready` with a programmable backpressure pattern, checks incoming data against an incrementing sequence, and reports beat and error counts plus the first mismatch. It sits on the output side of a FIFO in the bench or a bring-up build and stresses the FIFO's `m_valid`/`m_ready` path.

## Interface
- `DATA_WIDTH`, 32, stream data width
- `CNT_WIDTH`, 32, width of beat and error counters
- `LFSR_SEED`, 16'hACE1, LFSR load value; a seed of 0 is replaced by 16'h0001
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle pulse: clear stats, load expected value, enter RUN
- `stop`  in  1  one-cycle pulse: return to IDLE
- `throttle_mode`  in  2  0 always ready, 1 LFSR random, 2 ready one cycle in four, 3 never ready
- `expect_start`  in  DATA_WIDTH  first expected data value, sampled on `start`
- `s_valid`  in  1  upstream valid
- `s_ready`  out  1  ready to upstream, registered
- `s_data`  in  DATA_WIDTH  upstream data
- `busy`  out  1  high in RUN
- `beat_count`  out  CNT_WIDTH  accepted beats since `start`, saturating
- `err_count`  out  CNT_WIDTH  mismatched beats since `start`, saturating
- `err_flag`  out  1  sticky; set on first mismatch
- `first_err_data`  out  DATA_WIDTH  `s_data` of first mismatch
- `first_err_expect`  out  DATA_WIDTH  expected value at first mismatch

## Operation
- States: IDLE, RUN.
- IDLE: `s_ready`=0, no transfers, stats held and readable.
- IDLE to RUN on `start`. Same edge: `expected`<=`expect_start`, both counters<=0, `err_flag`<=0, first-error registers<=0, LFSR<=seed, phase counter<=0.
- `start` in RUN performs the same restart and stays in RUN.
- RUN to IDLE on `stop`. If `start` and `stop` coincide, `start` wins.
- Transfer: `s_valid && s_ready` in RUN.
  - `beat_count`+1, saturating at all-ones.
  - If `s_data != expected`: `err_count`+1 (saturating). If `err_flag`=0, capture `first_err_data`/`first_err_expect` and set `err_flag`.
  - Resync policy: `expected`<=`s_data`+1, modulo 2^DATA_WIDTH, whether or not the beat matched. One dropped beat gives one error. One corrupted beat gives two errors.
- Wrap: `expected` all-ones followed by data all-ones gives next expected 0, with no error.
- Throttle, RUN only, with next `s_ready` computed from the current mode:
  - Mode 0: 1.
  - Mode 1: `lfsr[0]`. 16-bit Fibonacci LFSR, taps 16,14,13,11, shifts every RUN cycle.
  - Mode 2: 1 when the 2-bit phase counter equals 3. The counter increments every RUN cycle.
  - Mode 3: 0.
- `s_ready` never depends combinationally on `s_valid`. Once asserted it may drop whether or not a transfer occurred; the upstream must hold data while valid.
- `throttle_mode` may change in RUN; it takes effect on the next `s_ready` update.

## Timing
- Reset: state IDLE. All outputs 0, including `s_ready`, `busy`, counters, `err_flag`, and first-error registers. LFSR=seed, expected=0.
- Reset asserted mid-RUN aborts at that edge: the stats are lost, and a transfer presented in that cycle is not counted.
- `start` sampled in cycle N:
  - `busy`=1 and `s_ready`=f(mode) in cycle N+1.
  - A transfer is possible in cycle N+1 at the earliest.
- Transfer in cycle T: counters, `err_flag`, and `expected` update in cycle T+1.
- `stop` sampled in cycle N:
  - A transfer in cycle N still counts.
  - `s_ready`=0 and `busy`=0 from cycle N+1.
- Mode 0 sustains one beat per cycle.
- Mode 2 sustains one beat per four cycles, with `s_ready` high in cycles N+4, N+8, … after `start`.

## Test plan
- Mode 0, `expect_start`=0x10, upstream sends 0x10..0x1F back-to-back, then `stop` -> `beat_count`=16, `err_count`=0, `err_flag`=0, `s_ready` high in every cycle from N+1 until `stop`.
- Mode 0, send 0x00,0x01,0x03,0x04 (drop) -> `err_count`=1, `first_err_data`=0x03, `first_err_expect`=0x02. Then send 0x05,0x07,0x06 (swap) -> `err_count`=3, first-error registers unchanged.
- Mode 1 through FIFO top, 1000 incrementing beats from 0 -> `beat_count`=1000, `err_count`=0. `s_ready` matches a reference LFSR from seed 0xACE1.
- Mode 2, `s_valid` held high -> `s_ready` high only in cycles N+4k. 8 beats take 32 cycles.
- Wrap, `expect_start`=0xFFFFFFFE, send FFFFFFFE, FFFFFFFF, 0, 1 -> 0 errors. `start` mid-stream -> counters 0 the next cycle. `rst` mid-RUN -> all outputs 0 the next cycle.
- Mode 3, `s_valid` high for 20 cycles -> `s_ready`=0 and `beat_count`=0 throughout. Then `start` and `stop` in the same cycle -> `busy`=1 the next cycle.
